// File: rtl/move_input_ctrl_pkg.sv
// Shared constants and types for the movement input conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package move_input_ctrl_pkg;

  // Direction indices; also the bit order of o_Held and the arbiter priority (lowest index wins)
  localparam int DIR_UP   = 0;
  localparam int DIR_DN   = 1;
  localparam int DIR_LT   = 2;
  localparam int DIR_RT   = 3;
  localparam int NUM_DIRS = 4;

  // Default timing at 25 MHz; the raccoon controller derives its speed constants from these
  localparam int DEF_DEBOUNCE_CYCLES = 250000;   // 10 ms
  localparam int DEF_REPEAT_DELAY    = 7500000;  // 300 ms
  localparam int DEF_REPEAT_PERIOD   = 3750000;  // 150 ms

  // Per-switch press / auto-repeat state
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_LOCKED = 2'd3
  } mv_state_e;

  // Counter width for a count range of n; never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/move_input_ctrl_if.sv
// Switch/enable inputs and move/held outputs of the movement input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; move pulses are fire-and-forget.
interface move_input_ctrl_if;
  logic       i_Switch_Up;
  logic       i_Switch_Dn;
  logic       i_Switch_Lt;
  logic       i_Switch_Rt;
  logic       i_Enable;
  logic       o_Move_Up;
  logic       o_Move_Dn;
  logic       o_Move_Lt;
  logic       o_Move_Rt;
  logic [3:0] o_Held;

  // Game side: drives switches and enable, consumes move requests
  modport master (
    output i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt, i_Enable,
    input  o_Move_Up, o_Move_Dn, o_Move_Lt, o_Move_Rt, o_Held
  );

  // Conditioner side
  modport slave (
    input  i_Switch_Up, i_Switch_Dn, i_Switch_Lt, i_Switch_Rt, i_Enable,
    output o_Move_Up, o_Move_Dn, o_Move_Lt, o_Move_Rt, o_Held
  );
endinterface

// File: rtl/move_input_ctrl_button_debounce.sv
// 2-FF synchroniser plus stable-run debounce for one raw switch.
// Latency: level changes 2+DEBOUNCE_CYCLES cycles after a clean raw edge.
// Backpressure: none.
module button_debounce
  import move_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic sw_i,
  output logic level_o,      // debounced level
  output logic level_nxt_o   // value level_o takes after the next edge
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the debounced level
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser and debounce state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/move_input_ctrl.sv
// Turns four raw direction switches into one-hot move pulses with press + auto-repeat.
// Latency: first pulse 3+DEBOUNCE_CYCLES cycles after a clean press, plus arbitration wait.
// Backpressure: none; pending requests wait in per-direction flags, duplicates are absorbed.
module move_input_ctrl
  import move_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic              i_Clk,
  input logic              i_Rst_n,
  move_input_ctrl_if.slave bus
);

  localparam int            RW          = max_int(cnt_width(REPEAT_DELAY), cnt_width(REPEAT_PERIOD));
  localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_ONE     = RW'(1);

  logic [NUM_DIRS-1:0] raw_sw;
  logic [NUM_DIRS-1:0] held_lvl;   // debounced level now
  logic [NUM_DIRS-1:0] held_nxt;   // debounced level after this edge
  logic [NUM_DIRS-1:0] pend_q;
  logic [NUM_DIRS-1:0] eligible;
  logic [NUM_DIRS-1:0] grant;
  logic [NUM_DIRS-1:0] move_q;
  mv_state_e           state_q [NUM_DIRS];
  logic [RW-1:0]       rpt_q   [NUM_DIRS];

  assign raw_sw = {bus.i_Switch_Rt, bus.i_Switch_Lt, bus.i_Switch_Dn, bus.i_Switch_Up};

  for (genvar g = 0; g < NUM_DIRS; g++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i       (i_Clk),
      .rst_n_i     (i_Rst_n),
      .sw_i        (raw_sw[g]),
      .level_o     (held_lvl[g]),
      .level_nxt_o (held_nxt[g])
    );
  end

  // Serve the lowest-index live flag; a flag whose switch is releasing or locked out is void
  always_comb begin
    eligible = pend_q & held_nxt & {NUM_DIRS{bus.i_Enable}};
    grant    = eligible & (~eligible + {{(NUM_DIRS-1){1'b0}}, 1'b1});
  end

  // Press / auto-repeat FSMs, repeat counters and pending flags for all four directions
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int i = 0; i < NUM_DIRS; i++) begin
        state_q[i] <= ST_IDLE;
        rpt_q[i]   <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DIRS; i++) begin
        if (!bus.i_Enable) begin
          // Lockout: a switch still held must be released before it can move again
          state_q[i] <= held_nxt[i] ? ST_LOCKED : ST_IDLE;
          rpt_q[i]   <= '0;
          pend_q[i]  <= 1'b0;
        end else begin
          if (rpt_q[i] != '0) rpt_q[i] <= rpt_q[i] - RPT_ONE;
          if (grant[i]) pend_q[i] <= 1'b0;
          unique case (state_q[i])
            ST_IDLE: begin
              if (held_nxt[i] && !held_lvl[i]) begin
                state_q[i] <= ST_DELAY;
                pend_q[i]  <= 1'b1;
                rpt_q[i]   <= DELAY_LOAD;
              end
            end
            ST_DELAY, ST_REPEAT: begin
              if (!held_nxt[i]) begin
                state_q[i] <= ST_IDLE;
                pend_q[i]  <= 1'b0;
                rpt_q[i]   <= '0;
              end else if (rpt_q[i] == '0) begin
                state_q[i] <= ST_REPEAT;
                pend_q[i]  <= 1'b1;
                rpt_q[i]   <= PERIOD_LOAD;
              end
            end
            ST_LOCKED: begin
              if (!held_nxt[i]) state_q[i] <= ST_IDLE;
            end
            default: state_q[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Registered one-hot move pulses
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      move_q <= '0;
    end else begin
      move_q <= grant;
    end
  end

  assign bus.o_Move_Up = move_q[DIR_UP];
  assign bus.o_Move_Dn = move_q[DIR_DN];
  assign bus.o_Move_Lt = move_q[DIR_LT];
  assign bus.o_Move_Rt = move_q[DIR_RT];
  assign bus.o_Held    = held_lvl;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Bench for move_input_ctrl: cycle model of the switch rules plus directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_move_input_ctrl;
  import move_input_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  move_input_ctrl_if bus_if ();

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_n(rst_n),
    .bus    (bus_if)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_no     = 0;

  always @(posedge clk) edge_no <= edge_no + 1;

  logic [3:0] dut_mv;
  assign dut_mv = {bus_if.o_Move_Rt, bus_if.o_Move_Lt, bus_if.o_Move_Dn, bus_if.o_Move_Up};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw inputs reach the debouncer two edges late; the debounced level flips after DEB
  // consecutive disagreeing samples. A recognised press schedules requests at absolute
  // edge numbers: press, press+DLY, then every PER edges, while held and enabled.
  int         now_m = 0;
  logic [3:0] m_s1 = '0, m_s2 = '0, m_held = '0, m_pend = '0, m_move = '0;
  logic [3:0] m_raw, m_old_sync, m_new_held;
  int         m_run    [4];
  bit         m_active [4];
  bit         m_locked [4];
  int         m_next   [4];
  int         m_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_held = '0; m_pend = '0; m_move = '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_active[i] = 0; m_locked[i] = 0; m_next[i] = 0;
      end
    end else begin
      m_raw      = {bus_if.i_Switch_Rt, bus_if.i_Switch_Lt, bus_if.i_Switch_Dn, bus_if.i_Switch_Up};
      m_old_sync = m_s2;
      m_s2       = m_s1;
      m_s1       = m_raw;
      m_new_held = m_held;
      for (int i = 0; i < 4; i++) begin
        if (m_old_sync[i] != m_held[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_new_held[i] = ~m_held[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_g = -1;
      for (int i = 0; i < 4; i++)
        if (m_g < 0 && m_pend[i] && bus_if.i_Enable && m_new_held[i]) m_g = i;
      m_move = '0;
      if (m_g >= 0) begin
        m_move[m_g] = 1'b1;
        m_pend[m_g] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        if (!bus_if.i_Enable) begin
          m_pend[i] = 1'b0; m_active[i] = 0; m_locked[i] = m_new_held[i];
        end else if (m_locked[i]) begin
          if (!m_new_held[i]) m_locked[i] = 0;
        end else if (m_active[i]) begin
          if (!m_new_held[i]) begin
            m_active[i] = 0; m_pend[i] = 1'b0;
          end else if (now_m == m_next[i]) begin
            m_pend[i] = 1'b1; m_next[i] = m_next[i] + PER;
          end
        end else if (m_new_held[i] && !m_held[i]) begin
          m_active[i] = 1; m_pend[i] = 1'b1; m_next[i] = now_m + DLY;
        end
      end
      m_held = m_new_held;
      now_m++;
    end
  end

  // ---------------- compare + event log ----------------
  int         mv_log [4][16];
  int         mv_cnt [4];
  int         rise_t [4];
  logic [3:0] prev_held = '0;
  int         n_hi;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("held_vs_model", bus_if.o_Held, m_held);
      check("move_vs_model", dut_mv, m_move);
      n_hi = $countones(dut_mv);
      check("move_one_hot", (n_hi <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
    for (int d = 0; d < 4; d++) begin
      if (dut_mv[d] === 1'b1 && mv_cnt[d] < 16) begin
        mv_log[d][mv_cnt[d]] = edge_no;
        mv_cnt[d]++;
      end
      if (bus_if.o_Held[d] === 1'b1 && prev_held[d] === 1'b0) rise_t[d] = edge_no;
    end
    prev_held = bus_if.o_Held;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    for (int d = 0; d < 4; d++) begin
      mv_cnt[d] = 0;
      rise_t[d] = -1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  int t0;
  initial begin
    rst_n = 1'b0;
    bus_if.i_Switch_Up = 1'b1;
    bus_if.i_Switch_Dn = 1'b0;
    bus_if.i_Switch_Lt = 1'b0;
    bus_if.i_Switch_Rt = 1'b0;
    bus_if.i_Enable    = 1'b1;
    clear_log();
    cyc(3);
    check("reset_held", bus_if.o_Held, 0);
    check("reset_move", dut_mv, 0);

    // Up held through reset: held at 6, pulses at 7, 17, 22, 27
    rst_n = 1'b1;
    t0 = edge_no;
    cyc(24);
    bus_if.i_Switch_Up = 1'b0;
    cyc(16);
    check("up_rise_cycle", rise_t[DIR_UP] - t0, 6);
    check("up_pulse_count", mv_cnt[DIR_UP], 4);
    check("up_pulse0_cycle", mv_log[DIR_UP][0] - t0, 7);
    check("up_pulse1_cycle", mv_log[DIR_UP][1] - t0, 17);
    check("up_pulse2_cycle", mv_log[DIR_UP][2] - t0, 22);
    check("up_pulse3_cycle", mv_log[DIR_UP][3] - t0, 27);

    // Bounce: 3 high / 3 low never settles
    clear_log();
    for (int k = 0; k < 40; k++) begin
      bus_if.i_Switch_Up = ((k / 3) % 2 == 0);
      cyc(1);
      check("bounce_held", bus_if.o_Held, 0);
    end
    bus_if.i_Switch_Up = 1'b0;
    cyc(10);
    check("bounce_pulses", mv_cnt[DIR_UP], 0);

    // Simultaneous Up + Rt: Up first, Rt one cycle later
    clear_log();
    bus_if.i_Switch_Up = 1'b1;
    bus_if.i_Switch_Rt = 1'b1;
    t0 = edge_no;
    cyc(8);
    bus_if.i_Switch_Up = 1'b0;
    bus_if.i_Switch_Rt = 1'b0;
    cyc(12);
    check("simul_up_count", mv_cnt[DIR_UP], 1);
    check("simul_up_cycle", mv_log[DIR_UP][0] - t0, 7);
    check("simul_rt_count", mv_cnt[DIR_RT], 1);
    check("simul_rt_cycle", mv_log[DIR_RT][0] - t0, 8);

    // Enable lockout while Dn repeats
    clear_log();
    bus_if.i_Switch_Dn = 1'b1;
    t0 = edge_no;
    cyc(20);
    check("lock_pre_count", mv_cnt[DIR_DN], 2);
    bus_if.i_Enable = 1'b0;
    cyc(20);
    bus_if.i_Enable = 1'b1;
    cyc(20);
    check("lock_post_count", mv_cnt[DIR_DN], 2);
    check("lock_held_still", bus_if.o_Held, 4'b0010);
    bus_if.i_Switch_Dn = 1'b0;
    cyc(12);
    clear_log();
    bus_if.i_Switch_Dn = 1'b1;
    t0 = edge_no;
    cyc(9);
    bus_if.i_Switch_Dn = 1'b0;
    check("repress_count", mv_cnt[DIR_DN], 1);
    check("repress_cycle", mv_log[DIR_DN][0] - t0, 7);
    cyc(12);

    // Lt released so its debounced level drops 8 cycles after the first pulse
    clear_log();
    bus_if.i_Switch_Lt = 1'b1;
    t0 = edge_no;
    cyc(9);
    bus_if.i_Switch_Lt = 1'b0;
    cyc(16);
    check("lt_count", mv_cnt[DIR_LT], 1);
    check("lt_cycle", mv_log[DIR_LT][0] - t0, 7);

    // Asynchronous reset while Rt is pulsing
    clear_log();
    bus_if.i_Switch_Rt = 1'b1;
    t0 = edge_no;
    cyc(22);
    check("arst_pre_move", bus_if.o_Move_Rt, 1);
    check("arst_pre_held", bus_if.o_Held, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_move", dut_mv, 0);
    check("arst_held", bus_if.o_Held, 0);
    cyc(2);
    clear_log();
    rst_n = 1'b1;
    t0 = edge_no;
    cyc(9);
    bus_if.i_Switch_Rt = 1'b0;
    check("arst_restart_count", mv_cnt[DIR_RT], 1);
    check("arst_restart_cycle", mv_log[DIR_RT][0] - t0, 7);
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/move_input_ctrl.md
# move_input_ctrl

Conditions the four raw direction switches into clean, rate-limited move-request pulses for the raccoon movement controller, which sits directly downstream. Each switch is synchronised, debounced, and turned into one pulse per press, followed by auto-repeat while the switch is held. A one-per-cycle priority arbiter ensures the downstream controller never sees two directions in the same cycle. An enable input locks out all movement during collision or respawn until the player releases the switches.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required before the debounced level changes (10 ms at 25 MHz).
- `REPEAT_DELAY`, 7500000: cycles from the first pulse to the first auto-repeat pulse (300 ms).
- `REPEAT_PERIOD`, 3750000: cycles between subsequent auto-repeat pulses (150 ms).
- `i_Clk` input 1: system clock; all logic on its rising edge.
- `i_Rst_n` input 1: asynchronous, active-low reset.
- `i_Switch_Up`, `i_Switch_Dn`, `i_Switch_Lt`, `i_Switch_Rt` input 1 each: raw, active-high, asynchronous switches.
- `i_Enable` input 1: movement permitted when high; driven low by the game during collision or respawn.
- `o_Move_Up`, `o_Move_Dn`, `o_Move_Lt`, `o_Move_Rt` output 1 each: single-cycle move requests, at most one high per cycle.
- `o_Held` output 4: debounced switch levels, in the order {Rt, Lt, Dn, Up}.

## Operation
- **Synchronisation:** each switch passes through a 2-FF synchroniser.
- **Debounce:** there is one counter per switch.
  - The counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES`-1, the debounced level toggles and the counter clears.
- **Per-switch FSM states:** IDLE, DELAY, REPEAT, LOCKED.
  - IDLE + debounced rise → DELAY: raise the pending flag and load the repeat counter with `REPEAT_DELAY`-1.
  - DELAY + counter at 0 → REPEAT: raise the pending flag and load `REPEAT_PERIOD`-1.
  - REPEAT + counter at 0: raise the pending flag, reload `REPEAT_PERIOD`-1, and stay in REPEAT.
  - DELAY or REPEAT + debounced low → IDLE; this also clears the pending flag.
  - Any state with `i_Enable`=0 → LOCKED, if the switch is debounced high. Otherwise → IDLE.
  - All pending flags clear while `i_Enable` is 0.
  - LOCKED + debounced low → IDLE. No pulse is ever issued from LOCKED.
- **Arbiter:**
  - Each cycle, the highest-priority pending flag is served, with priority Up > Dn > Lt > Rt.
  - Serving a flag clears it and drives the matching `o_Move_*` next cycle.
  - Unserved flags wait for later cycles. A flag already pending absorbs a new request; requests are not counted.
- **Counter widths:** counters are sized by `$clog2` of their parameter. Counters saturate and never wrap.
- **Reset:** all outputs are 0; `o_Held` is 0; FSMs are in IDLE; counters and pending flags are 0; synchroniser registers are 0.
  - A switch held through reset produces a normal press once debounced.

## Timing
- Raw edge at cycle 0 (stable): the synchroniser output changes at cycle 2.
- Debounced level and `o_Held` change at cycle 2+`DEBOUNCE_CYCLES`.
- The pending flag is set on the same cycle as the debounced level change.
- `o_Move_*` is high at cycle 3+`DEBOUNCE_CYCLES` if no higher-priority flag is pending. The pulse is exactly 1 cycle wide.
- First repeat pulse: `REPEAT_DELAY` cycles after the first pulse. Subsequent repeats: every `REPEAT_PERIOD` cycles, plus arbitration wait.
- Release while a flag is pending and not yet served: the flag drops and no pulse is issued.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no change on `o_Held` and no pulse.
- `i_Enable` falling: takes effect the next cycle. No `o_Move_*` is high after the cycle in which `i_Enable` is sampled low.
- Reset asserted mid-operation: all outputs clear immediately, asynchronously.

## Structure
- **Shared package/header:**
  - direction indices `DIR_UP`=0, `DIR_DN`=1, `DIR_LT`=2, `DIR_RT`=3
  - FSM state encodings
  - default timing constants, shared with the raccoon controller's speed constants
- **Sub-module `button_debounce`:** synchroniser plus debounce counter, with parameter `DEBOUNCE_CYCLES` and output of the debounced level. Instantiated four times.
- **Top level:** contains the four FSMs, the repeat counters and the arbiter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5.
- **Reset with Up held:** reset released with Up held → `o_Held`[0] rises at cycle 6; `o_Move_Up` pulses at cycle 7, then at 17, 22 and 27 while held.
- **Bounce rejection:** Up toggled with 3-cycle highs and 3-cycle lows for 40 cycles → `o_Held` stays 0 and no pulses.
- **Simultaneous press:** Up and Rt pressed in the same cycle → `o_Move_Up` at cycle 7 and `o_Move_Rt` at cycle 8; never both high.
- **Enable lockout:** Dn held and repeating, then `i_Enable`=0 for 20 cycles, then 1 with Dn still held → no pulses.
  - Then release Dn and press again → a pulse 7 cycles after the re-press.
- **Release before repeat:** Lt pressed for 8 cycles after its first pulse → exactly one `o_Move_Lt` and no repeats.
- **Asynchronous reset mid-repeat:** `i_Rst_n` low mid-repeat → all outputs 0 in the same cycle, and the FSM restarts from IDLE.
